// File: rtl/multicycle_rv_core.sv
// Multicycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB control around one shared ALU.
// Instructions are pushed in over a valid/ready port; data memory is internal and not reset.
module multicycle_rv_core #(
    parameter int              XLEN       = 32,
    parameter int              NREGS      = 32,
    parameter int              DMEM_WORDS = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic            busy,
    output logic            retire,
    output logic            illegal,
    output logic [XLEN-1:0] pc_dbg,
    output logic [XLEN-1:0] alu_result_dbg,
    output logic [XLEN-1:0] result_dbg,
    output logic [4:0]      rd_dbg
);
    localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);
    localparam logic [5:0] NR = 6'(NREGS);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_ALU_R, C_ALU_I, C_LW, C_SW, C_BEQ, C_JAL, C_JALR, C_BAD} cls_t;
    typedef enum logic [2:0] {A_ADD, A_SUB, A_AND, A_OR, A_SLT} aop_t;

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc, a, b, aluout, mdr;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] dmem [DMEM_WORDS];

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    cls_t            cls;
    aop_t            aop, alu_op;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm, alu_x, alu_y, alu_out, pc4, wb_val;
    logic [AW-1:0]   word;
    logic            use_rs1, use_rs2, use_rd, bad_reg;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    always_comb begin
        cls   = C_BAD;
        aop   = A_ADD;
        imm32 = '0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  begin cls = C_ALU_R; aop = A_ADD; end
                        3'b010:  begin cls = C_ALU_R; aop = A_SLT; end
                        3'b110:  begin cls = C_ALU_R; aop = A_OR;  end
                        3'b111:  begin cls = C_ALU_R; aop = A_AND; end
                        default: cls = C_BAD;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    cls = C_ALU_R;
                    aop = A_SUB;
                end
            end
            7'b0010011: begin
                imm32 = {{20{ir[31]}}, ir[31:20]};
                case (funct3)
                    3'b000:  begin cls = C_ALU_I; aop = A_ADD; end
                    3'b010:  begin cls = C_ALU_I; aop = A_SLT; end
                    3'b110:  begin cls = C_ALU_I; aop = A_OR;  end
                    3'b111:  begin cls = C_ALU_I; aop = A_AND; end
                    default: cls = C_BAD;
                endcase
            end
            7'b0000011: begin
                imm32 = {{20{ir[31]}}, ir[31:20]};
                if (funct3 == 3'b010) cls = C_LW;
            end
            7'b0100011: begin
                imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                if (funct3 == 3'b010) cls = C_SW;
            end
            7'b1100011: begin
                imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                if (funct3 == 3'b000) cls = C_BEQ;
            end
            7'b1101111: begin
                imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                cls   = C_JAL;
            end
            7'b1100111: begin
                imm32 = {{20{ir[31]}}, ir[31:20]};
                if (funct3 == 3'b000) cls = C_JALR;
            end
            default: cls = C_BAD;
        endcase
        // Register fields that the format actually uses must exist (RV32E-style configs)
        use_rs1 = (cls != C_JAL) && (cls != C_BAD);
        use_rs2 = (cls == C_ALU_R) || (cls == C_SW) || (cls == C_BEQ);
        use_rd  = (cls == C_ALU_R) || (cls == C_ALU_I) || (cls == C_LW) ||
                  (cls == C_JAL) || (cls == C_JALR);
        bad_reg = (use_rs1 && {1'b0, rs1} >= NR) || (use_rs2 && {1'b0, rs2} >= NR) ||
                  (use_rd && {1'b0, rd} >= NR);
        if (bad_reg) cls = C_BAD;
    end

    if (XLEN > 32) begin : g_imm_wide
        assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_imm_narrow
        assign imm = imm32[XLEN-1:0];
    end

    always_comb begin
        alu_x  = (cls == C_JAL) ? pc : a;
        alu_y  = (cls == C_ALU_R) ? b : imm;
        alu_op = (cls == C_ALU_R || cls == C_ALU_I) ? aop : A_ADD;
        case (alu_op)
            A_SUB:   alu_out = alu_x - alu_y;
            A_AND:   alu_out = alu_x & alu_y;
            A_OR:    alu_out = alu_x | alu_y;
            A_SLT:   alu_out = {{(XLEN-1){1'b0}}, ($signed(alu_x) < $signed(alu_y))};
            default: alu_out = alu_x + alu_y;
        endcase
    end

    assign pc4    = pc + FOUR;
    assign word   = aluout[AW+1:2];
    assign wb_val = (cls == C_LW) ? mdr :
                    (cls == C_JAL || cls == C_JALR) ? pc4 : aluout;

    assign instr_ready    = (state == S_FETCH);
    assign busy           = (state != S_FETCH);
    assign pc_dbg         = pc;
    assign alu_result_dbg = aluout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            aluout     <= '0;
            mdr        <= '0;
            result_dbg <= '0;
            rd_dbg     <= '0;
            retire     <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            retire  <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a <= regs[rs1[RW-1:0]];
                    b <= regs[rs2[RW-1:0]];
                    if (cls == C_BAD) begin
                        retire  <= 1'b1;
                        illegal <= 1'b1;
                        pc      <= pc4;
                        state   <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_BEQ: begin
                            pc     <= (a == b) ? pc + imm : pc4;
                            retire <= 1'b1;
                            state  <= S_FETCH;
                        end
                        C_LW, C_SW: begin
                            aluout <= alu_out;
                            state  <= S_MEM;
                        end
                        C_JALR: begin
                            aluout <= {alu_out[XLEN-1:1], 1'b0};
                            state  <= S_WB;
                        end
                        default: begin
                            aluout <= alu_out;
                            state  <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (cls == C_SW) begin
                        pc     <= pc4;
                        retire <= 1'b1;
                        state  <= S_FETCH;
                    end else begin
                        mdr   <= dmem[word];
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    if (rd != 5'd0) regs[rd[RW-1:0]] <= wb_val;
                    result_dbg <= wb_val;
                    rd_dbg     <= rd;
                    pc         <= (cls == C_JAL || cls == C_JALR) ? aluout : pc4;
                    retire     <= 1'b1;
                    state      <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_MEM && cls == C_SW) dmem[word] <= b;
    end
endmodule

// File: tb/tb_multicycle_rv_core.sv
// Bench for multicycle_rv_core: directed literal programs, then random instructions
// checked against an instruction-level model (register file, memory words, PC).
module tb_multicycle_rv_core;
    localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_SLT = 4;
    localparam int OP_ADDI = 5, OP_ANDI = 6, OP_ORI = 7, OP_SLTI = 8;
    localparam int OP_LW = 9, OP_SW = 10, OP_BEQ = 11, OP_JAL = 12, OP_JALR = 13, OP_ILL = 14;

    logic        clk, rst_n, instr_valid;
    logic [31:0] instr;
    logic        instr_ready, busy, retire, illegal;
    logic [31:0] pc_dbg, alu_result_dbg, result_dbg;
    logic [4:0]  rd_dbg;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [64];
    logic [31:0] m_pc;
    logic [31:0] last_res;
    logic [4:0]  last_rd;

    multicycle_rv_core dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .busy(busy), .retire(retire), .illegal(illegal),
        .pc_dbg(pc_dbg), .alu_result_dbg(alu_result_dbg), .result_dbg(result_dbg),
        .rd_dbg(rd_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_pc", pc_dbg, 32'h0);
        chk("rst_ready", {31'b0, instr_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_result", result_dbg, 32'h0);
        chk("rst_rd", {27'b0, rd_dbg}, 32'd0);
        chk("rst_alu", alu_result_dbg, 32'h0);
    endtask

    // Called at a negedge with the core expected in FETCH; returns at the retire negedge.
    task automatic run_instr(input logic [31:0] word, input int lat, input bit ill,
                             input logic [31:0] exp_pc, input logic [31:0] exp_res,
                             input logic [4:0] exp_rd, input bit chk_alu,
                             input logic [31:0] exp_alu, input bit hold);
        int waited = 0;
        while (!instr_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) chk("ready_timeout", {31'b0, instr_ready}, 32'd1);
        instr       = word;
        instr_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                if (hold) begin
                    instr_valid = 1'b1;
                    instr       = $urandom;
                end else begin
                    instr_valid = 1'b0;
                end
                chk("busy", {31'b0, busy}, 32'd1);
                chk("ready_low", {31'b0, instr_ready}, 32'd0);
                chk("retire_early", {31'b0, retire}, 32'd0);
            end else begin
                instr_valid = 1'b0;
                chk("retire", {31'b0, retire}, 32'd1);
                chk("illegal", {31'b0, illegal}, {31'b0, ill});
                chk("pc", pc_dbg, exp_pc);
                chk("result", result_dbg, exp_res);
                chk("rd", {27'b0, rd_dbg}, {27'b0, exp_rd});
                if (chk_alu) chk("alu", alu_result_dbg, exp_alu);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc     = 32'h0;
        last_res = 32'h0;
        last_rd  = 5'd0;
    endtask

    function automatic logic [31:0] encode(input int op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        logic [31:0] w;
        w = 32'hFFFF_FFFF;
        case (op)
            OP_ADD:  w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            OP_SUB:  w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            OP_AND:  w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            OP_OR:   w = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            OP_SLT:  w = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
            OP_ADDI: w = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            OP_ANDI: w = {imm[11:0], rs1, 3'b111, rd, 7'b0010011};
            OP_ORI:  w = {imm[11:0], rs1, 3'b110, rd, 7'b0010011};
            OP_SLTI: w = {imm[11:0], rs1, 3'b010, rd, 7'b0010011};
            OP_LW:   w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            OP_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            OP_BEQ:  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            OP_JAL:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            OP_JALR: w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            default: w = 32'hFFFF_FFFF;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] illegal_word(input int kind, input logic [4:0] rd,
                                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                                 input logic [31:0] r);
        case (kind)
            1:       return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
            2:       return {r[11:0], rs1, 3'b001, rd, 7'b0010011};
            3:       return {r[11:0], rs1, 3'b000, rd, 7'b0000011};
            4:       return {7'b0, rs2, rs1, 3'b001, 5'b0, 7'b1100011};
            5:       return {r[19:0], rd, 7'b0110111};
            6:       return {7'b0100000, rs2, rs1, 3'b111, rd, 7'b0110011};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Architectural effect of one instruction, plus the retire latency it must show.
    task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                         input logic [31:0] imm, input logic [31:0] word, input bit hold);
        logic [31:0] a, b, ea, res, nxt, alu;
        int lat;
        bit ill, wb, chk_alu;
        a   = m_regs[rs1];
        b   = m_regs[rs2];
        ea  = a + imm;
        nxt = m_pc + 32'd4;
        res = 32'h0;
        alu = 32'h0;
        lat = 4; ill = 0; wb = 1; chk_alu = 1;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_ADDI: res = ea;
            OP_ANDI: res = a & imm;
            OP_ORI:  res = a | imm;
            OP_SLTI: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_LW:   begin lat = 5; res = m_mem[int'((ea >> 2) % 64)]; alu = ea; end
            OP_SW:   begin wb = 0; m_mem[int'((ea >> 2) % 64)] = b; alu = ea; end
            OP_BEQ:  begin lat = 3; wb = 0; chk_alu = 0; if (a == b) nxt = m_pc + imm; end
            OP_JAL:  begin res = m_pc + 32'd4; alu = m_pc + imm; nxt = alu; end
            OP_JALR: begin res = m_pc + 32'd4; alu = ea & ~32'd1; nxt = alu; end
            default: begin lat = 2; ill = 1; wb = 0; chk_alu = 0; end
        endcase
        if (op <= OP_SLTI) alu = res;
        if (wb) begin
            if (rd != 0) m_regs[rd] = res;
            last_res = res;
            last_rd  = 5'(rd);
        end
        m_pc = nxt;
        run_instr(word, lat, ill, m_pc, last_res, last_rd, chk_alu, alu, hold);
    endtask

    function automatic int pick_reg();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    endfunction

    task automatic rand_instr();
        int op, rd, rs1, rs2;
        logic [11:0] r12;
        logic [19:0] r20;
        logic [31:0] imm, word;
        op  = $urandom_range(0, 14);
        rd  = pick_reg();
        rs1 = pick_reg();
        rs2 = ($urandom_range(0, 3) == 0) ? rs1 : pick_reg();
        r12 = 12'($urandom);
        r20 = 20'($urandom);
        imm = {{20{r12[11]}}, r12};
        if (op == OP_BEQ) imm = {{19{r12[11]}}, r12, 1'b0};
        if (op == OP_JAL) imm = {{11{r20[19]}}, r20, 1'b0};
        if (op == OP_ILL)
            word = illegal_word($urandom_range(0, 6), 5'(rd), 5'(rs1), 5'(rs2), {12'b0, r20});
        else
            word = encode(op, 5'(rd), 5'(rs1), 5'(rs2), imm);
        issue(op, rd, rs1, rs2, imm, word, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst_n       = 1'b1;
        instr       = 32'h0;
        instr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed program: literal words and literal expectations
        run_instr(32'h00500093, 4, 0, 32'h04, 32'd5,  5'd1, 1, 32'd5,  0);
        run_instr(32'h00700113, 4, 0, 32'h08, 32'd7,  5'd2, 1, 32'd7,  0);
        run_instr(32'h002081B3, 4, 0, 32'h0C, 32'd12, 5'd3, 1, 32'd12, 0);
        run_instr(32'hFFFFFFFF, 2, 1, 32'h10, 32'd12, 5'd3, 0, 32'd0,  1);
        run_instr(32'h00108463, 3, 0, 32'h18, 32'd12, 5'd3, 0, 32'd0,  1);
        run_instr(32'h00208463, 3, 0, 32'h1C, 32'd12, 5'd3, 0, 32'd0,  0);
        run_instr(32'h00302423, 4, 0, 32'h20, 32'd12, 5'd3, 1, 32'd8,  0);
        run_instr(32'h010002EF, 4, 0, 32'h30, 32'h24, 5'd5, 1, 32'h30, 1);
        run_instr(32'h00802203, 5, 0, 32'h34, 32'd12, 5'd4, 1, 32'd8,  0);
        run_instr(32'h00028333, 4, 0, 32'h38, 32'h24, 5'd6, 1, 32'h24, 0);

        // Reset while lw x4,8(x0) sits in EXEC
        instr       = 32'h00802203;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(32'h00018333, 4, 0, 32'h04, 32'd0,  5'd6, 1, 32'd0, 0);
        run_instr(32'h00802383, 5, 0, 32'h08, 32'd12, 5'd7, 1, 32'd8, 0);

        // Random phase: fresh reset, clear every memory word, then random traffic
        do_reset();
        for (int i = 0; i < 64; i++)
            issue(OP_SW, 0, 0, 0, 32'(4 * i), encode(OP_SW, 5'd0, 5'd0, 5'd0, 32'(4 * i)), 0);
        for (int n = 0; n < 500; n++) rand_instr();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
